// File: rtl/apple1_pkg.sv
// Shared encodings for the apple1 button conditioner: debounce-channel and
// reset-sequencer state machines, plus a counter sizing helper.
package apple1_pkg;

  localparam int NUM_BUTTONS = 3;

  typedef enum logic [1:0] {
    CH_UP        = 2'd0,
    CH_WAIT_DOWN = 2'd1,
    CH_DOWN      = 2'd2,
    CH_WAIT_UP   = 2'd3
  } ch_state_t;

  typedef enum logic [1:0] {
    RST_HOLD    = 2'd0,
    RST_STRETCH = 2'd1,
    RST_RUN     = 2'd2
  } rst_state_t;

  // Counter width for a terminal count of n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button conditioner bundle: raw buttons in, debounced levels, edge pulses,
// conditioned core reset and FSM debug visibility out.
interface button_conditioner_if import apple1_pkg::*; ();

  // No handshake: every output is a registered level or a one-cycle pulse,
  // valid on every clk25 cycle; consumers sample them synchronously.
  logic [NUM_BUTTONS-1:0]   button_n;
  logic [NUM_BUTTONS-1:0]   btn_level;
  logic [NUM_BUTTONS-1:0]   btn_press;
  logic [NUM_BUTTONS-1:0]   btn_release;
  logic                     sys_rst_n;

  // Debug: per-channel FSM state (2 bits each), next debounced level, reset FSM state.
  logic [2*NUM_BUTTONS-1:0] ch_state;
  logic [NUM_BUTTONS-1:0]   level_next;
  rst_state_t               rst_state;

  modport master (
    input  button_n,
    output btn_level, btn_press, btn_release, sys_rst_n,
    output ch_state, level_next, rst_state
  );

  modport slave (
    output button_n,
    input  btn_level, btn_press, btn_release, sys_rst_n,
    input  ch_state, level_next, rst_state
  );

endinterface

// File: rtl/button_debounce_ch.sv
// One button channel: two-flop synchronizer, stability counter and the
// UP/WAIT_DOWN/DOWN/WAIT_UP debounce FSM with registered level and pulses.
module button_debounce_ch import apple1_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      button_n,
  output logic      level,
  output logic      level_next,
  output logic      press_pulse,
  output logic      release_pulse,
  output ch_state_t state
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  // The sample that enters WAIT_* is stable sample one, so the last count is N-2.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [1:0]    sync_q;
  logic          pressed;
  ch_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], button_n};
    end
  end

  assign pressed = ~sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CH_UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      CH_UP: begin
        if (pressed) begin
          state_d = CH_WAIT_DOWN;
          cnt_d   = '0;
        end
      end
      CH_WAIT_DOWN: begin
        if (!pressed) begin
          state_d = CH_UP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CH_DOWN;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CH_DOWN: begin
        if (!pressed) begin
          state_d = CH_WAIT_UP;
          cnt_d   = '0;
        end
      end
      CH_WAIT_UP: begin
        if (pressed) begin
          state_d = CH_DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = CH_UP;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = CH_UP;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level         = level_q;
  assign level_next    = level_d;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign state         = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Three debounced DE0 buttons plus a reset sequencer that turns button 0 into
// a stretched, glitch-free active-low reset for the apple1 core.
module button_conditioner import apple1_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RESET_STRETCH   = 65536
) (
  input  logic                 clk25,
  input  logic                 rst_n,
  button_conditioner_if.master bus
);

  localparam int SW = cnt_width(RESET_STRETCH);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(RESET_STRETCH - 1);

  logic [NUM_BUTTONS-1:0]   level;
  logic [NUM_BUTTONS-1:0]   level_next;
  logic [NUM_BUTTONS-1:0]   press;
  logic [NUM_BUTTONS-1:0]   release_v;
  logic [2*NUM_BUTTONS-1:0] ch_state_v;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    ch_state_t st;

    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk           (clk25),
      .rst_n         (rst_n),
      .button_n      (bus.button_n[i]),
      .level         (level[i]),
      .level_next    (level_next[i]),
      .press_pulse   (press[i]),
      .release_pulse (release_v[i]),
      .state         (st)
    );

    assign ch_state_v[2*i +: 2] = st;
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = release_v;
  assign bus.ch_state    = ch_state_v;
  assign bus.level_next  = level_next;

  rst_state_t    rst_state_q, rst_state_d;
  logic [SW-1:0] rst_cnt_q, rst_cnt_d;
  logic          sys_rst_q, sys_rst_d;

  // Power-on starts mid-sequence in STRETCH so rst_n release yields a full pulse.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      rst_state_q <= RST_STRETCH;
      rst_cnt_q   <= '0;
      sys_rst_q   <= 1'b0;
    end else begin
      rst_state_q <= rst_state_d;
      rst_cnt_q   <= rst_cnt_d;
      sys_rst_q   <= sys_rst_d;
    end
  end

  // HOLD/STRETCH follow button 0's level as it is being registered, so the
  // stretch begins on the same edge btn_level[0] falls. RUN reacts to the
  // registered press pulse, which drops sys_rst_n the cycle after the pulse.
  always_comb begin
    rst_state_d = rst_state_q;
    rst_cnt_d   = rst_cnt_q;
    case (rst_state_q)
      RST_HOLD: begin
        if (!level_next[0]) begin
          rst_state_d = RST_STRETCH;
          rst_cnt_d   = '0;
        end
      end
      RST_STRETCH: begin
        if (level_next[0]) begin
          rst_state_d = RST_HOLD;
        end else if (rst_cnt_q == STRETCH_LAST) begin
          rst_state_d = RST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + SW'(1);
        end
      end
      RST_RUN: begin
        if (press[0]) begin
          rst_state_d = RST_HOLD;
        end
      end
      default: begin
        rst_state_d = RST_HOLD;
      end
    endcase
    sys_rst_d = (rst_state_d == RST_RUN);
  end

  assign bus.sys_rst_n = sys_rst_q;
  assign bus.rst_state = rst_state_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short debounce and stretch
// lengths; output events are scoreboarded by kind and cycle of appearance.
module tb_button_conditioner;
  import apple1_pkg::*;

  localparam int DB  = 8;
  localparam int RS  = 16;
  localparam int LAT = 2 + DB;

  // Event kinds: press i -> i, release i -> 4+i, sys_rst_n rise -> 8, fall -> 9.
  localparam logic [7:0] EV_RISE = 8'd8;
  localparam logic [7:0] EV_FALL = 8'd9;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic prev_sys;

  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];

  button_conditioner_if bus();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .RESET_STRETCH  (RS)
  ) dut (
    .clk25 (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: collect output events each negedge and match them in order.
  always @(negedge clk) begin
    obs_q.delete();
    if (rst_n !== 1'b1) begin
      prev_sys = 1'b0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++)
        if (bus.btn_press[i] !== 1'b0) obs_q.push_back({8'(i), 32'(cyc)});
      for (int i = 0; i < NUM_BUTTONS; i++)
        if (bus.btn_release[i] !== 1'b0) obs_q.push_back({8'(4 + i), 32'(cyc)});
      if (prev_sys === 1'b0 && bus.sys_rst_n === 1'b1) obs_q.push_back({EV_RISE, 32'(cyc)});
      if (prev_sys === 1'b1 && bus.sys_rst_n !== 1'b1) obs_q.push_back({EV_FALL, 32'(cyc)});
      prev_sys = bus.sys_rst_n;
      foreach (obs_q[k]) begin
        logic [39:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got kind %0d at cycle %0d, expected no event",
                   obs_q[k][39:32], obs_q[k][31:0]);
        end else begin
          e = exp_q.pop_front();
          if (obs_q[k] !== e) begin
            n_fail++;
            $display("FAIL sb_event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     obs_q[k][39:32], obs_q[k][31:0], e[39:32], e[31:0]);
          end
        end
      end
    end
  end

  // Driver tasks: inputs change 2 time units after a negedge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic expect_ev(input logic [7:0] kind, input int at);
    exp_q.push_back({kind, 32'(at)});
  endtask

  task automatic drain(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d events still pending, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    int c;
    rst_n        = 1'b0;
    bus.button_n = 3'b111;
    repeat (3) tick();
    n_checks++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.sys_rst_n} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {bus.btn_level, bus.btn_press, bus.btn_release, bus.sys_rst_n});
    end
    n_checks++;
    if (bus.rst_state !== RST_STRETCH) begin
      n_fail++;
      $display("FAIL reset_rst_state: got %0d, expected %0d", bus.rst_state, RST_STRETCH);
    end
    bus.button_n = 3'b000;
    repeat (4) tick();
    n_checks++;
    if (bus.btn_level !== 3'b000 || bus.ch_state !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_held_buttons: got level %b state %b, expected 000 / 000000",
               bus.btn_level, bus.ch_state);
    end
    bus.button_n = 3'b111;
    repeat (4) tick();
    c = cyc;
    expect_ev(EV_RISE, c + RS);
    rst_n = 1'b1;
    tick_to(c + RS - 1);
    n_checks++;
    if (bus.sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL por_early: got sys_rst_n %b, expected 0", bus.sys_rst_n);
    end
    tick_to(c + RS);
    n_checks++;
    if (bus.sys_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL por_release: got sys_rst_n %b, expected 1", bus.sys_rst_n);
    end
    repeat (5) tick();
    drain("por");
  endtask

  task automatic test_clean_press();
    int c;
    c = cyc;
    expect_ev(8'd1, c + LAT);
    bus.button_n[1] = 1'b0;
    tick_to(c + LAT - 1);
    n_checks++;
    if (bus.btn_level[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL press1_early: got level %b, expected 0", bus.btn_level[1]);
    end
    tick_to(c + LAT);
    n_checks++;
    if (bus.btn_level[1] !== 1'b1 || bus.btn_press[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL press1_edge: got level %b press %b, expected 1 1",
               bus.btn_level[1], bus.btn_press[1]);
    end
    tick_to(c + 30);
    c = cyc;
    expect_ev(8'd5, c + LAT);
    bus.button_n[1] = 1'b1;
    tick_to(c + LAT);
    n_checks++;
    if (bus.btn_level[1] !== 1'b0 || bus.btn_release[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL release1_edge: got level %b release %b, expected 0 1",
               bus.btn_level[1], bus.btn_release[1]);
    end
    repeat (5) tick();
    drain("clean1");
  endtask

  task automatic test_bounce();
    int c;
    int lo;
    int hi;
    for (int r = 0; r < 5; r++) begin
      lo = (r < 3) ? 5 : int'($urandom_range(1, DB - 1));
      hi = (r < 3) ? 3 : int'($urandom_range(1, DB - 1));
      bus.button_n[2] = 1'b0;
      repeat (lo) tick();
      bus.button_n[2] = 1'b1;
      repeat (hi) tick();
    end
    n_checks++;
    if (bus.btn_level[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_press_level: got %b, expected 0", bus.btn_level[2]);
    end
    c = cyc;
    expect_ev(8'd2, c + LAT);
    bus.button_n[2] = 1'b0;
    tick_to(c + LAT + 10);
    for (int r = 0; r < 3; r++) begin
      bus.button_n[2] = 1'b1;
      repeat ($urandom_range(1, DB - 1)) tick();
      bus.button_n[2] = 1'b0;
      repeat ($urandom_range(1, DB - 1)) tick();
    end
    n_checks++;
    if (bus.btn_level[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_release_level: got %b, expected 1", bus.btn_level[2]);
    end
    c = cyc;
    expect_ev(8'd6, c + LAT);
    bus.button_n[2] = 1'b1;
    tick_to(c + LAT + 5);
    drain("bounce2");
  endtask

  task automatic test_reset_button();
    int c;
    c = cyc;
    expect_ev(8'd0, c + LAT);
    expect_ev(EV_FALL, c + LAT + 1);
    expect_ev(8'd4, c + 40 + LAT);
    expect_ev(EV_RISE, c + 40 + LAT + RS);
    bus.button_n[0] = 1'b0;
    tick_to(c + 30);
    n_checks++;
    if (bus.sys_rst_n !== 1'b0 || bus.rst_state !== RST_HOLD) begin
      n_fail++;
      $display("FAIL btn0_hold: got sys_rst_n %b state %0d, expected 0 %0d",
               bus.sys_rst_n, bus.rst_state, RST_HOLD);
    end
    tick_to(c + 40);
    bus.button_n[0] = 1'b1;
    tick_to(c + 40 + LAT + RS - 1);
    n_checks++;
    if (bus.sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL btn0_stretch: got sys_rst_n %b, expected 0", bus.sys_rst_n);
    end
    tick_to(c + 40 + LAT + RS + 5);
    drain("btn0");
  endtask

  task automatic test_stretch_repress();
    int c;
    c = cyc;
    expect_ev(8'd0, c + LAT);
    expect_ev(EV_FALL, c + LAT + 1);
    expect_ev(8'd4, c + 20 + LAT);
    expect_ev(8'd0, c + 35 + LAT);
    expect_ev(8'd4, c + 60 + LAT);
    expect_ev(EV_RISE, c + 60 + LAT + RS);
    bus.button_n[0] = 1'b0;
    tick_to(c + 20);
    bus.button_n[0] = 1'b1;
    tick_to(c + 35);
    bus.button_n[0] = 1'b0;
    tick_to(c + 20 + LAT + RS + 2);
    n_checks++;
    if (bus.sys_rst_n !== 1'b0 || bus.rst_state !== RST_HOLD) begin
      n_fail++;
      $display("FAIL repress_hold: got sys_rst_n %b state %0d, expected 0 %0d",
               bus.sys_rst_n, bus.rst_state, RST_HOLD);
    end
    tick_to(c + 60);
    bus.button_n[0] = 1'b1;
    tick_to(c + 60 + LAT + RS + 5);
    drain("repress");
  endtask

  task automatic test_simultaneous();
    int c;
    c = cyc;
    for (int i = 0; i < NUM_BUTTONS; i++) expect_ev(8'(i), c + LAT);
    expect_ev(EV_FALL, c + LAT + 1);
    for (int i = 0; i < NUM_BUTTONS; i++) expect_ev(8'(4 + i), c + 20 + LAT);
    expect_ev(EV_RISE, c + 20 + LAT + RS);
    bus.button_n = 3'b000;
    tick_to(c + LAT);
    n_checks++;
    if (bus.btn_press !== 3'b111 || bus.btn_level !== 3'b111) begin
      n_fail++;
      $display("FAIL simul_press: got press %b level %b, expected 111 111",
               bus.btn_press, bus.btn_level);
    end
    tick_to(c + 20);
    bus.button_n = 3'b111;
    tick_to(c + 20 + LAT + RS + 5);
    drain("simul");
  endtask

  task automatic test_reset_mid_debounce();
    int c;
    int d;
    c = cyc;
    expect_ev(8'd1, c + LAT);
    bus.button_n[1] = 1'b0;
    tick_to(c + 20);
    bus.button_n[1] = 1'b1;
    bus.button_n[2] = 1'b0;
    tick_to(c + 25);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.sys_rst_n} !== 10'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b, expected all zero",
               {bus.btn_level, bus.btn_press, bus.btn_release, bus.sys_rst_n});
    end
    n_checks++;
    if (bus.ch_state !== 6'b0 || bus.rst_state !== RST_STRETCH) begin
      n_fail++;
      $display("FAIL midreset_states: got ch %b rst %0d, expected 000000 %0d",
               bus.ch_state, bus.rst_state, RST_STRETCH);
    end
    tick();
    bus.button_n[2] = 1'b1;
    repeat (3) tick();
    d = cyc;
    expect_ev(EV_RISE, d + RS);
    rst_n = 1'b1;
    tick_to(d + RS + LAT + 5);
    n_checks++;
    if (bus.btn_level !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_level: got %b, expected 000", bus.btn_level);
    end
    drain("midreset");
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    prev_sys     = 1'b0;
    rst_n        = 1'b0;
    bus.button_n = 3'b111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_reset_button();
    test_stretch_repress();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
